// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and defaults for the L1 data-cache miss controller
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_DATA,
    ST_RF_REQ,
    ST_RF_DATA,
    ST_DONE
  } dcache_state_t;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_WORD_W      = 32;
  localparam int DEF_BLOCK_WORDS = 16;

  function automatic int word_idx_w(input int block_words);
    return $clog2(block_words);
  endfunction

endpackage

// File: rtl/burst_counter.sv
// rtl/burst_counter.sv - beat counter for cache-line bursts with clear, increment and last-beat flag
module burst_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // Line size is a power of two, so natural wrap keeps the count inside the line.
  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = &r_cnt;

endmodule

// File: rtl/dcache_miss_fsm.sv
// rtl/dcache_miss_fsm.sv - write-back D-cache miss FSM: stall, victim writeback, line refill (DCACHE_PERF_CNT_EN adds miss/wb counters)
module dcache_miss_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_access,
  input  logic                           i_hit,
  input  logic                           i_dirty,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic [ADDR_W-1:0]              i_victim_tag,
  input  logic [WORD_W-1:0]              i_victim_word,
  output logic                           o_stall_d,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
  output logic                           o_fill_we,
  output logic                           o_fill_done,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDR_W-1:0]              o_mem_addr,
  input  logic                           i_mem_req_rdy,
  output logic                           o_mem_wvalid,
  output logic [WORD_W-1:0]              o_mem_wdata,
  input  logic                           i_mem_wready,
`ifdef DCACHE_PERF_CNT_EN
  output logic [63:0]                    o_miss_cnt,
  output logic [63:0]                    o_wb_cnt,
`endif
  input  logic                           i_mem_rvalid,
  input  logic [WORD_W-1:0]              i_mem_rdata
);

  localparam int OFFSET_W = $clog2(BLOCK_WORDS * WORD_W / 8);
  localparam int IDX_W    = word_idx_w(BLOCK_WORDS);

  dcache_state_t     r_state;
  logic [ADDR_W-1:0] r_miss_line;
  logic [ADDR_W-1:0] r_victim_base;

  logic              w_miss;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_cnt_last;
  logic [IDX_W-1:0]  w_cnt;
  logic              w_unused;

  assign w_miss = i_access & ~i_hit;

  assign w_cnt_clr = ((r_state == ST_WB_REQ) || (r_state == ST_RF_REQ)) && i_mem_req_rdy;
  assign w_cnt_inc = ((r_state == ST_WB_DATA) && i_mem_wready) ||
                     ((r_state == ST_RF_DATA) && i_mem_rvalid);

  burst_counter #(.W(IDX_W)) u_beat_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_clear(w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_cnt  (w_cnt),
    .o_last (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_miss_line   <= '0;
      r_victim_base <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Capture both addresses now; the MEM-stage address may move while stalled.
          if (w_miss) begin
            r_miss_line   <= {i_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            r_victim_base <= i_victim_tag;
            r_state       <= i_dirty ? ST_WB_REQ : ST_RF_REQ;
          end
        end
        ST_WB_REQ:  if (i_mem_req_rdy) r_state <= ST_WB_DATA;
        ST_WB_DATA: if (i_mem_wready && w_cnt_last) r_state <= ST_RF_REQ;
        ST_RF_REQ:  if (i_mem_req_rdy) r_state <= ST_RF_DATA;
        ST_RF_DATA: if (i_mem_rvalid && w_cnt_last) r_state <= ST_DONE;
        ST_DONE:    r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [63:0] r_miss_cnt;
  logic [63:0] r_wb_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else if ((r_state == ST_IDLE) && w_miss) begin
      r_miss_cnt <= r_miss_cnt + 64'd1;
      if (i_dirty) r_wb_cnt <= r_wb_cnt + 64'd1;
    end
  end

  assign o_miss_cnt = r_miss_cnt;
  assign o_wb_cnt   = r_wb_cnt;
`endif

  assign o_stall_d    = (r_state != ST_IDLE) || w_miss;
  assign o_word_idx   = w_cnt;
  assign o_fill_we    = (r_state == ST_RF_DATA) && i_mem_rvalid;
  assign o_fill_done  = (r_state == ST_DONE);
  assign o_mem_req    = (r_state == ST_WB_REQ) || (r_state == ST_RF_REQ);
  assign o_mem_we     = (r_state == ST_WB_REQ);
  assign o_mem_wvalid = (r_state == ST_WB_DATA);
  assign o_mem_wdata  = o_mem_wvalid ? i_victim_word : '0;
  assign o_mem_addr   = (r_state == ST_WB_REQ) ? r_victim_base :
                        (r_state == ST_RF_REQ) ? r_miss_line   : '0;

  // Byte offset and refill data are consumed by the cache array, not by this controller.
  assign w_unused = ^{i_addr[OFFSET_W-1:0], i_mem_rdata};

endmodule

// File: tb/tb_dcache_miss_fsm.sv
// tb/tb_dcache_miss_fsm.sv - directed self-checking bench for dcache_miss_fsm
module tb_dcache_miss_fsm;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_access, i_hit, i_dirty;
  logic [31:0] i_addr, i_victim_tag, i_victim_word;
  logic        o_stall_d;
  logic [3:0]  o_word_idx;
  logic        o_fill_we, o_fill_done, o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr;
  logic        i_mem_req_rdy;
  logic        o_mem_wvalid;
  logic [31:0] o_mem_wdata;
  logic        i_mem_wready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
`ifdef DCACHE_PERF_CNT_EN
  logic [63:0] o_miss_cnt, o_wb_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_miss = 0;
  int exp_wb = 0;

  always #5 clk = ~clk;

  // Cache read port model: victim word is a function of the requested index.
  always_comb i_victim_word = 32'hA500_0000 | {28'd0, o_word_idx};

  dcache_miss_fsm dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_access     (i_access),
    .i_hit        (i_hit),
    .i_dirty      (i_dirty),
    .i_addr       (i_addr),
    .i_victim_tag (i_victim_tag),
    .i_victim_word(i_victim_word),
    .o_stall_d    (o_stall_d),
    .o_word_idx   (o_word_idx),
    .o_fill_we    (o_fill_we),
    .o_fill_done  (o_fill_done),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .i_mem_req_rdy(i_mem_req_rdy),
    .o_mem_wvalid (o_mem_wvalid),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_wready (i_mem_wready),
`ifdef DCACHE_PERF_CNT_EN
    .o_miss_cnt   (o_miss_cnt),
    .o_wb_cnt     (o_wb_cnt),
`endif
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  task automatic test_reset;
    rstn = 1'b0; i_access = 1'b0; i_hit = 1'b0; i_dirty = 1'b0;
    i_addr = '0; i_victim_tag = '0; i_mem_req_rdy = 1'b0;
    i_mem_wready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_miss = 0; exp_wb = 0;
    #1;
    checks++;
    if ({o_stall_d, o_fill_we, o_fill_done, o_mem_req, o_mem_we, o_mem_wvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {o_stall_d, o_fill_we, o_fill_done, o_mem_req, o_mem_we, o_mem_wvalid});
    end
    checks++;
    if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", o_mem_addr); end
    checks++;
    if (o_word_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", o_word_idx); end
    checks++;
    if (o_mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", o_mem_wdata); end
  endtask

  task automatic test_hit;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_access = 1'b1; i_hit = 1'b1; i_dirty = k[0]; i_addr = 32'h0000_4000 + k * 4;
      #1;
      checks++;
      if (o_stall_d !== 1'b0) begin errors++; $display("FAIL hit_stall: got %b expected 0", o_stall_d); end
      checks++;
      if (o_mem_req !== 1'b0) begin errors++; $display("FAIL hit_req: got %b expected 0", o_mem_req); end
    end
    @(negedge clk);
    i_access = 1'b0; i_hit = 1'b0;
  endtask

  task automatic req_phase(input string tag, input logic we, input logic [31:0] addr, input int req_wait);
    for (int k = 0; k <= req_wait; k++) begin
      @(negedge clk);
      i_access = 1'b0; i_addr = 32'hFFFF_FFFF;
      i_mem_wready = 1'b0; i_mem_rvalid = 1'b0;
      i_mem_req_rdy = (k == req_wait);
      #1;
      checks++;
      if (o_mem_req !== 1'b1) begin errors++; $display("FAIL %s_req: got %b expected 1", tag, o_mem_req); end
      checks++;
      if (o_mem_we !== we) begin errors++; $display("FAIL %s_we: got %b expected %b", tag, o_mem_we, we); end
      checks++;
      if (o_mem_addr !== addr) begin errors++; $display("FAIL %s_addr: got %h expected %h", tag, o_mem_addr, addr); end
      checks++;
      if (o_stall_d !== 1'b1) begin errors++; $display("FAIL %s_stall: got %b expected 1", tag, o_stall_d); end
    end
  endtask

  task automatic wb_phase(input string tag, input bit gaps);
    int b = 0;
    int cyc = 0;
    while (b < 16 && cyc < 200) begin
      @(negedge clk);
      i_mem_req_rdy = 1'b0;
      i_mem_wready  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_mem_rvalid  = gaps ? ($urandom_range(0, 1) != 0) : 1'b0;
      #1;
      checks++;
      if (o_mem_wvalid !== 1'b1) begin errors++; $display("FAIL %s_wvalid: got %b expected 1", tag, o_mem_wvalid); end
      checks++;
      if (o_word_idx !== b[3:0]) begin errors++; $display("FAIL %s_idx: got %0d expected %0d", tag, o_word_idx, b); end
      checks++;
      if (o_mem_wdata !== (32'hA500_0000 | b)) begin
        errors++; $display("FAIL %s_wdata: got %h expected %h", tag, o_mem_wdata, 32'hA500_0000 | b);
      end
      checks++;
      if ({o_fill_we, o_mem_req, o_stall_d} !== 3'b001) begin
        errors++; $display("FAIL %s_ctl: got %b expected 001", tag, {o_fill_we, o_mem_req, o_stall_d});
      end
      if (i_mem_wready) b++;
      cyc++;
    end
    checks++;
    if (b != 16) begin errors++; $display("FAIL %s_timeout: got %0d beats expected 16", tag, b); end
  endtask

  task automatic rf_phase(input string tag, input bit gaps, input int nbeats);
    int b = 0;
    int cyc = 0;
    while (b < nbeats && cyc < 200) begin
      @(negedge clk);
      i_mem_req_rdy = 1'b0;
      i_mem_rvalid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_mem_wready  = gaps ? ($urandom_range(0, 1) != 0) : 1'b0;
      i_mem_rdata   = 32'hD000_0000 | b;
      #1;
      checks++;
      if (o_word_idx !== b[3:0]) begin errors++; $display("FAIL %s_idx: got %0d expected %0d", tag, o_word_idx, b); end
      checks++;
      if (o_fill_we !== i_mem_rvalid) begin
        errors++; $display("FAIL %s_fill_we: got %b expected %b", tag, o_fill_we, i_mem_rvalid);
      end
      checks++;
      if ({o_mem_wvalid, o_mem_req, o_fill_done, o_stall_d} !== 4'b0001) begin
        errors++;
        $display("FAIL %s_ctl: got %b expected 0001", tag, {o_mem_wvalid, o_mem_req, o_fill_done, o_stall_d});
      end
      if (i_mem_rvalid) b++;
      cyc++;
    end
    checks++;
    if (b != nbeats) begin errors++; $display("FAIL %s_timeout: got %0d beats expected %0d", tag, b, nbeats); end
  endtask

  task automatic run_miss(input string tag, input logic [31:0] addr, input logic dirty,
                          input logic [31:0] victim, input int req_wait, input bit gaps);
    logic [31:0] line;
    line = addr & 32'hFFFF_FFC0;
    @(negedge clk);
    i_access = 1'b1; i_hit = 1'b0; i_dirty = dirty; i_addr = addr; i_victim_tag = victim;
    i_mem_req_rdy = 1'b0; i_mem_wready = 1'b0; i_mem_rvalid = 1'b0;
    #1;
    checks++;
    if (o_stall_d !== 1'b1) begin errors++; $display("FAIL %s_miss_stall: got %b expected 1", tag, o_stall_d); end
    checks++;
    if (o_mem_req !== 1'b0) begin errors++; $display("FAIL %s_miss_req: got %b expected 0", tag, o_mem_req); end
    exp_miss++;
    if (dirty) begin
      exp_wb++;
      req_phase({tag, "_wbreq"}, 1'b1, victim, req_wait);
      wb_phase({tag, "_wb"}, gaps);
    end
    req_phase({tag, "_rfreq"}, 1'b0, line, req_wait);
    rf_phase({tag, "_rf"}, gaps, 16);
    @(negedge clk);
    i_mem_rvalid = 1'b1; i_mem_wready = 1'b1;
    #1;
    checks++;
    if ({o_fill_done, o_stall_d, o_fill_we, o_mem_wvalid} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_done: got %b expected 1100", tag, {o_fill_done, o_stall_d, o_fill_we, o_mem_wvalid});
    end
    @(negedge clk);
    i_mem_rvalid = 1'b0; i_mem_wready = 1'b0;
    i_access = 1'b1; i_hit = 1'b1; i_addr = addr;
    #1;
    checks++;
    if ({o_stall_d, o_fill_done, o_mem_req} !== 3'b000) begin
      errors++; $display("FAIL %s_release: got %b expected 000", tag, {o_stall_d, o_fill_done, o_mem_req});
    end
    @(negedge clk);
    i_access = 1'b0; i_hit = 1'b0;
  endtask

  task automatic test_reset_mid_refill;
    @(negedge clk);
    i_access = 1'b1; i_hit = 1'b0; i_dirty = 1'b0; i_addr = 32'h0000_3344;
    exp_miss++;
    req_phase("rst_rfreq", 1'b0, 32'h0000_3340, 0);
    rf_phase("rst_rf", 1'b0, 7);
    @(negedge clk);
    i_mem_rvalid = 1'b1;
    #1;
    checks++;
    if (o_word_idx !== 4'd7) begin errors++; $display("FAIL rst_beat7_idx: got %0d expected 7", o_word_idx); end
    rstn = 1'b0; i_access = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_miss = 0; exp_wb = 0;
    #1;
    checks++;
    if ({o_stall_d, o_fill_we, o_fill_done, o_mem_req, o_mem_we, o_mem_wvalid} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b expected 000000",
               {o_stall_d, o_fill_we, o_fill_done, o_mem_req, o_mem_we, o_mem_wvalid});
    end
    checks++;
    if (o_word_idx !== 4'd0 || o_mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mid_idx_addr: got %0d/%h expected 0/0", o_word_idx, o_mem_addr);
    end
    i_mem_rvalid = 1'b0;
    run_miss("post_rst", 32'h0000_5678, 1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_perf;
`ifdef DCACHE_PERF_CNT_EN
    run_miss("perf_c0", 32'h0000_0100, 1'b0, 32'h0, 0, 1'b0);
    run_miss("perf_d0", 32'h0000_0200, 1'b1, 32'h0000_9000, 0, 1'b0);
    run_miss("perf_c1", 32'h0000_0300, 1'b0, 32'h0, 0, 1'b0);
    run_miss("perf_d1", 32'h0000_0400, 1'b1, 32'h0000_A000, 0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (o_miss_cnt !== 64'(exp_miss)) begin errors++; $display("FAIL perf_miss: got %0d expected %0d", o_miss_cnt, exp_miss); end
    checks++;
    if (o_wb_cnt !== 64'(exp_wb)) begin errors++; $display("FAIL perf_wb: got %0d expected %0d", o_wb_cnt, exp_wb); end
`endif
  endtask

  initial begin
    test_reset();
    test_hit();
    run_miss("clean", 32'h0000_1234, 1'b0, 32'h0000_7000, 0, 1'b0);
    run_miss("dirty", 32'h0000_1234, 1'b1, 32'h0000_8200, 0, 1'b0);
    run_miss("bp_clean", 32'h0000_2A7C, 1'b0, 32'h0, 5, 1'b1);
    run_miss("bp_dirty", 32'h0001_0F08, 1'b1, 32'h0000_C4C0, 5, 1'b1);
    test_reset_mid_refill();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
